// File: rtl/perf_event_counters.sv
// perf_event_counters: bank of NUM_EVENTS event counters with per-channel edge or
// level counting, wrap/saturate overflow handling, sticky overflow flags, a free
// cycle counter, an atomic snapshot bank and a registered read port.
module perf_event_counters #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [NUM_EVENTS-1:0] edge_mode,
  input  logic                  enable,
  input  logic                  sat_mode,
  input  logic                  clear,
  input  logic                  snapshot,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  input  logic                  rd_snapshot,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [NUM_EVENTS-1:0] overflow,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [NUM_EVENTS-1:0] prev_r;
  logic [NUM_EVENTS-1:0] ovf_r;
  logic [NUM_EVENTS-1:0] inc_s;
  logic [NUM_EVENTS-1:0] ovf_next_s;
  logic [CNT_WIDTH-1:0]  cnt_r      [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_r     [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_next_s [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cycle_r;
  logic [CNT_WIDTH-1:0]  cycle_next_s;
  logic [CNT_WIDTH-1:0]  rd_next_s;
  logic [CNT_WIDTH-1:0]  rd_data_r;

  // Qualify each channel's event: rising edge against prev or plain level, gated by enable.
  always_comb begin
    inc_s = {NUM_EVENTS{1'b0}};
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (edge_mode[i]) begin
        inc_s[i] = enable & event_in[i] & ~prev_r[i];
      end else begin
        inc_s[i] = enable & event_in[i];
      end
    end
  end

  // Next counter/overflow values; clear outranks increment, max+1 wraps or saturates.
  always_comb begin
    cnt_next_s = cnt_r;
    ovf_next_s = ovf_r;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (clear) begin
        cnt_next_s[i] = CNT_ZERO;
        ovf_next_s[i] = 1'b0;
      end else if (inc_s[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          cnt_next_s[i] = sat_mode ? CNT_MAX : CNT_ZERO;
          ovf_next_s[i] = 1'b1;
        end else begin
          cnt_next_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Cycle counter always wraps and carries no overflow flag.
  always_comb begin
    cycle_next_s = cycle_r;
    if (clear) begin
      cycle_next_s = CNT_ZERO;
    end else if (enable) begin
      cycle_next_s = cycle_r + CNT_ONE;
    end else begin
      cycle_next_s = cycle_r;
    end
  end

  // Read mux over pre-edge state; unpopulated channel selects read as zero.
  always_comb begin
    rd_next_s = CNT_ZERO;
    if (int'(rd_sel) < NUM_EVENTS) begin
      if (rd_snapshot) begin
        rd_next_s = snap_r[rd_sel];
      end else begin
        rd_next_s = cnt_r[rd_sel];
      end
    end else begin
      rd_next_s = CNT_ZERO;
    end
  end

  // Per-channel state; snapshot samples cnt before this edge's clear/increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= {NUM_EVENTS{1'b0}};
      ovf_r  <= {NUM_EVENTS{1'b0}};
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_r[i]  <= CNT_ZERO;
        snap_r[i] <= CNT_ZERO;
      end
    end else begin
      prev_r <= event_in;
      ovf_r  <= ovf_next_s;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_r[i] <= cnt_next_s[i];
        if (snapshot) begin
          snap_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Cycle counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_r   <= CNT_ZERO;
      rd_data_r <= CNT_ZERO;
    end else begin
      cycle_r   <= cycle_next_s;
      rd_data_r <= rd_next_s;
    end
  end

  assign rd_data     = rd_data_r;
  assign overflow    = ovf_r;
  assign cycle_count = cycle_r;

endmodule

// File: tb/tb_perf_event_counters.sv
// Self-checking bench for perf_event_counters (5 channels, 4-bit counters).
// A reference model updates on every rising clock; read requests push the
// expected rd_data into a queue that the scenario tasks pop and compare.
module tb_perf_event_counters;

  localparam int N = 5;
  localparam int W = 4;
  localparam int S = 3;

  logic         clk = 1'b1;
  logic         reset_n = 1'b0;
  logic [N-1:0] event_in = '0;
  logic [N-1:0] edge_mode = '0;
  logic         enable = 1'b0;
  logic         sat_mode = 1'b0;
  logic         clear = 1'b0;
  logic         snapshot = 1'b0;
  logic [S-1:0] rd_sel = '0;
  logic         rd_snapshot = 1'b0;
  logic [W-1:0] rd_data;
  logic [N-1:0] overflow;
  logic [W-1:0] cycle_count;

  int n_checks = 0;
  int n_fail = 0;
  logic chk_req = 1'b0;
  int exp_q[$];

  int m_cnt[N];
  int m_snap[N];
  int m_ovf[N];
  int m_prev[N];
  int m_cycle;

  perf_event_counters #(.NUM_EVENTS(N), .CNT_WIDTH(W), .SEL_WIDTH(S)) dut (
    .clk(clk), .reset_n(reset_n), .event_in(event_in), .edge_mode(edge_mode),
    .enable(enable), .sat_mode(sat_mode), .clear(clear), .snapshot(snapshot),
    .rd_sel(rd_sel), .rd_snapshot(rd_snapshot), .rd_data(rd_data),
    .overflow(overflow), .cycle_count(cycle_count)
  );

  // Rising edges at 10, 20, 30 ... ns; inputs change and outputs are sampled on falling edges.
  always #5 clk = ~clk;

  // Reference model of the counter bank and producer side of the read scoreboard.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 0; m_snap[i] <= 0; m_ovf[i] <= 0; m_prev[i] <= 0;
      end
      m_cycle <= 0;
    end else begin
      if (chk_req) begin
        if (int'(rd_sel) >= N) exp_q.push_back(0);
        else if (rd_snapshot) exp_q.push_back(m_snap[rd_sel]);
        else exp_q.push_back(m_cnt[rd_sel]);
      end
      for (int i = 0; i < N; i++) begin
        m_prev[i] <= event_in[i] ? 1 : 0;
        if (snapshot) m_snap[i] <= m_cnt[i];
        if (clear) begin
          m_cnt[i] <= 0;
          m_ovf[i] <= 0;
        end else if (enable && event_in[i] && !(edge_mode[i] && m_prev[i] != 0)) begin
          if (m_cnt[i] == (1 << W) - 1) begin
            m_ovf[i] <= 1;
            if (!sat_mode) m_cnt[i] <= 0;
          end else begin
            m_cnt[i] <= m_cnt[i] + 1;
          end
        end
      end
      if (clear) m_cycle <= 0;
      else if (enable) m_cycle <= (m_cycle + 1) % (1 << W);
    end
  end

  // Consumer side of the scoreboard; an empty queue yields a value rd_data can never equal.
  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic pulse(input int ch, input int times);
    for (int k = 0; k < times; k++) begin
      event_in[ch] = 1'b1;
      @(negedge clk);
      event_in[ch] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic clear_cycle();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    #32;
    n_checks++;
    if (rd_data !== 4'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    n_checks++;
    if (overflow !== 5'd0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 00000", overflow); end
    n_checks++;
    if (cycle_count !== 4'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d expected 0", cycle_count); end
    #3;
    reset_n = 1'b1;
    e = 0;
  endtask

  task automatic test_edge_count();
    int e;
    enable = 1'b1;
    edge_mode = 5'b00001;
    pulse(0, 5);
    rd_sel = 3'd0; rd_snapshot = 1'b0; chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e) begin n_fail++; $display("FAIL edge_sb: got %0d expected %0d", rd_data, e); end
    n_checks++;
    if (rd_data !== 4'd5) begin n_fail++; $display("FAIL edge_cnt0: got %0d expected 5", rd_data); end
    n_checks++;
    if (int'(cycle_count) !== m_cycle) begin n_fail++; $display("FAIL edge_cycle: got %0d expected %0d", cycle_count, m_cycle); end
  endtask

  task automatic test_level_count();
    int e;
    event_in[1] = 1'b1;
    repeat (7) @(negedge clk);
    event_in[1] = 1'b0;
    rd_sel = 3'd1; chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd7) begin n_fail++; $display("FAIL level_cnt1: got %0d expected 7 (model %0d)", rd_data, e); end
    clear_cycle();
    event_in[0] = 1'b1;
    repeat (7) @(negedge clk);
    event_in[0] = 1'b0;
    rd_sel = 3'd0; chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd1) begin n_fail++; $display("FAIL level_edge_cnt0: got %0d expected 1 (model %0d)", rd_data, e); end
  endtask

  task automatic test_wrap_saturate();
    int e;
    edge_mode = 5'b00101;
    for (int m = 0; m < 2; m++) begin
      sat_mode = (m == 1);
      clear_cycle();
      pulse(2, 17);
      n_checks++;
      if (overflow !== 5'b00100) begin n_fail++; $display("FAIL ovf_mode%0d: got %b expected 00100", m, overflow); end
      rd_sel = 3'd2; chk_req = 1'b1;
      @(negedge clk);
      chk_req = 1'b0;
      e = pop_exp();
      n_checks++;
      if (int'(rd_data) !== e || int'(rd_data) !== ((m == 1) ? 15 : 1)) begin
        n_fail++; $display("FAIL cnt2_mode%0d: got %0d expected %0d (model %0d)", m, rd_data, (m == 1) ? 15 : 1, e);
      end
    end
    clear_cycle();
    sat_mode = 1'b0;
    n_checks++;
    if (overflow !== 5'd0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 00000", overflow); end
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd0) begin n_fail++; $display("FAIL cnt2_clear: got %0d expected 0 (model %0d)", rd_data, e); end
  endtask

  task automatic test_atomic_snapshot();
    int e;
    clear_cycle();
    pulse(0, 9);
    event_in[0] = 1'b1; snapshot = 1'b1; clear = 1'b1;
    @(negedge clk);
    event_in[0] = 1'b0; snapshot = 1'b0; clear = 1'b0;
    rd_sel = 3'd0; rd_snapshot = 1'b1; chk_req = 1'b1;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd9) begin n_fail++; $display("FAIL snap0: got %0d expected 9 (model %0d)", rd_data, e); end
    rd_snapshot = 1'b0;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd0) begin n_fail++; $display("FAIL snap_live0: got %0d expected 0 (model %0d)", rd_data, e); end
  endtask

  task automatic test_enable_gating();
    int e;
    int exp_cyc;
    logic [3:0] pat;
    pat = 4'b1101;
    edge_mode = 5'b01101;
    pulse(3, 2);
    exp_cyc = m_cycle;
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      event_in[3] = pat[k];
      @(negedge clk);
    end
    n_checks++;
    if (int'(cycle_count) !== exp_cyc) begin n_fail++; $display("FAIL gate_cycle: got %0d expected %0d", cycle_count, exp_cyc); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    rd_sel = 3'd3; chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd2) begin n_fail++; $display("FAIL gate_cnt3: got %0d expected 2 (model %0d)", rd_data, e); end
  endtask

  task automatic test_reset_mid_run();
    int e;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 4'd0) begin n_fail++; $display("FAIL async_rd_data: got %0d expected 0", rd_data); end
    n_checks++;
    if (overflow !== 5'd0) begin n_fail++; $display("FAIL async_overflow: got %b expected 00000", overflow); end
    n_checks++;
    if (cycle_count !== 4'd0) begin n_fail++; $display("FAIL async_cycle: got %0d expected 0", cycle_count); end
    @(negedge clk);
    reset_n = 1'b1;
    event_in = 5'b00010;
    repeat (3) @(negedge clk);
    event_in = 5'b00000;
    rd_sel = 3'd1; chk_req = 1'b1;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd3) begin n_fail++; $display("FAIL resume_cnt1: got %0d expected 3 (model %0d)", rd_data, e); end
    rd_sel = 3'd5;
    @(negedge clk);
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd0) begin n_fail++; $display("FAIL oor_sel5: got %0d expected 0 (model %0d)", rd_data, e); end
    rd_sel = 3'd7; rd_snapshot = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
    e = pop_exp();
    n_checks++;
    if (int'(rd_data) !== e || rd_data !== 4'd0) begin n_fail++; $display("FAIL oor_sel7: got %0d expected 0 (model %0d)", rd_data, e); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_edge_count();
    test_level_count();
    test_wrap_saturate();
    test_atomic_snapshot();
    test_enable_gating();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks done %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
